pc_fetch_ctrl: RTL

//  Sequences the PC and the instruction-memory fetch handshake, and consumes the execute-stage branch decision (b_out).

---
 rtl/rv32_pkg.sv | 29 ++
 rtl/sat_counter.sv | 20 ++
 rtl/pc_fetch_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared types and defaults for the RV32 front end.
// Holds the fetch FSM states, the branch-type encoding and the reset defaults.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HOLD
    } fetch_state_t;

    typedef enum logic [2:0] {
        B_EQ,
        B_NE,
        B_LT,
        B_GE,
        B_LTU,
        B_GEU
    } b_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned CNT_W_DEFAULT    = 16;
    localparam int unsigned INSTR_W          = 32;

    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
// Counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!nRst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-memory fetch handshake.
// Applies branch/jump redirects from EX, flushing IF/ID and draining any in-flight fetch.
module pc_fetch_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned          CNT_W    = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               en,
    input  logic               branch_valid,
    input  logic               b_out,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               flush,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   branch_cnt,
    output logic [CNT_W-1:0]   taken_cnt
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pend_q, pend_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic               iv_q, iv_d;
    logic               mis_q, mis_d;

    logic               redirect;
    logic               take;
    logic [ADDR_W-1:0]  raw_tgt;
    logic [ADDR_W-1:0]  tgt;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            iv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            iv_q    <= iv_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        redirect = jump_valid | (branch_valid & b_out);
        raw_tgt  = jump_valid ? jump_target : branch_target;
        tgt      = {raw_tgt[ADDR_W-1:2], 2'b00};
        // Wrong-path redirects arriving while draining are already flushed
        take     = redirect && (state_q != DRAIN);

        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        iv_d     = iv_q;
        mis_d    = take && misaligned(raw_tgt[1:0]);
        imem_req = 1'b0;
        flush    = take && nRst;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (take) begin
                    pc_d = tgt;
                    iv_d = 1'b0;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (take) begin
                    iv_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    iv_d    = 1'b1;
                    pc_d    = pc_q + ADDR_W'(4);
                    if (!en) begin
                        state_d = HOLD;
                    end
                end else if (en) begin
                    iv_d = 1'b0;
                end
            end
            DRAIN: begin
                // Request stays up at the old pc until memory acknowledges it
                imem_req = 1'b1;
                iv_d     = 1'b0;
                if (imem_ack) begin
                    pc_d    = pend_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (take) begin
                    pc_d    = tgt;
                    iv_d    = 1'b0;
                    state_d = FETCH;
                end else if (en) begin
                    iv_d    = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = ipc_q;
    assign instr_valid  = iv_q;
    assign misalign_err = mis_q;

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk  (clk),
        .nRst (nRst),
        .inc  (branch_valid),
        .cnt  (branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk  (clk),
        .nRst (nRst),
        .inc  (branch_valid & b_out),
        .cnt  (taken_cnt)
    );

endmodule
